// File: rtl/mult_issue_rs.sv
// mult_issue_rs: multiply reservation station with CDB wakeup and per-FU issue.
// Define MULT_RS_AGE_SELECT_EN for oldest-first select; otherwise lowest entry index wins.
module mult_issue_rs #(
   parameter int RS_SIZE = 8,
   parameter int N       = 2,
   parameter int NUM_FU  = 2,
   parameter int TAG_W   = 6,
   parameter int DATA_W  = 32,
   parameter int ROB_W   = 5,
   parameter int OP_W    = 4,
   parameter int CNT_W   = $clog2(RS_SIZE+1)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     squash,
   input  logic [N-1:0]             dispatch_valid,
   input  logic [N*OP_W-1:0]        dispatch_op,
   input  logic [N-1:0]             dispatch_src1_ready,
   input  logic [N*TAG_W-1:0]       dispatch_src1_tag,
   input  logic [N*DATA_W-1:0]      dispatch_src1_value,
   input  logic [N-1:0]             dispatch_src2_ready,
   input  logic [N*TAG_W-1:0]       dispatch_src2_tag,
   input  logic [N*DATA_W-1:0]      dispatch_src2_value,
   input  logic [N*TAG_W-1:0]       dispatch_dest_tag,
   input  logic [N*ROB_W-1:0]       dispatch_rob_idx,
   input  logic [N-1:0]             cdb_valid,
   input  logic [N*TAG_W-1:0]       cdb_tag,
   input  logic [N*DATA_W-1:0]      cdb_value,
   input  logic [NUM_FU-1:0]        fu_avail,
   output logic [NUM_FU-1:0]        issue_valid,
   output logic [NUM_FU*OP_W-1:0]   issue_op,
   output logic [NUM_FU*DATA_W-1:0] issue_src1,
   output logic [NUM_FU*DATA_W-1:0] issue_src2,
   output logic [NUM_FU*TAG_W-1:0]  issue_dest_tag,
   output logic [NUM_FU*ROB_W-1:0]  issue_rob_idx,
   output logic [CNT_W-1:0]         free_count
);
   localparam int IDX_W = $clog2(RS_SIZE);
   typedef struct packed {
      logic              valid;
      logic [OP_W-1:0]   op;
      logic              r1;
      logic [TAG_W-1:0]  t1;
      logic [DATA_W-1:0] v1;
      logic              r2;
      logic [TAG_W-1:0]  t2;
      logic [DATA_W-1:0] v2;
      logic [TAG_W-1:0]  dest;
      logic [ROB_W-1:0]  rob;
   } ent_t;
   ent_t                    ent_q [RS_SIZE];
   ent_t                    ent_d [RS_SIZE];
   logic [NUM_FU-1:0]        iv_q, iv_d;
   logic [NUM_FU*OP_W-1:0]   iop_q, iop_d;
   logic [NUM_FU*DATA_W-1:0] is1_q, is1_d, is2_q, is2_d;
   logic [NUM_FU*TAG_W-1:0]  idest_q, idest_d;
   logic [NUM_FU*ROB_W-1:0]  irob_q, irob_d;
   logic [RS_SIZE-1:0]       taken, alloc;
   logic [NUM_FU-1:0]        sel_ok;
   logic [IDX_W-1:0]         sel_idx [NUM_FU];
   logic [CNT_W-1:0]         free_cnt, disp_cnt;
   logic                     found;
`ifdef MULT_RS_AGE_SELECT_EN
   logic [IDX_W-1:0]         age_q [RS_SIZE];
   logic [IDX_W-1:0]         age_d [RS_SIZE];
   logic [IDX_W-1:0]         best_age;
`endif
   always_comb begin
      ent_d    = ent_q;
      free_cnt = '0;
      disp_cnt = '0;
      taken    = '0;
      alloc    = '0;
      found    = 1'b0;
      iv_d     = '0;
      iop_d    = '0;
      is1_d    = '0;
      is2_d    = '0;
      idest_d  = '0;
      irob_d   = '0;
      sel_ok   = '0;
`ifdef MULT_RS_AGE_SELECT_EN
      age_d    = age_q;
      best_age = '0;
`endif
      for (int e = 0; e < RS_SIZE; e++) free_cnt = free_cnt + CNT_W'(!ent_q[e].valid);
      for (int i = 0; i < N; i++) disp_cnt = disp_cnt + CNT_W'(dispatch_valid[i]);
      // select: each available FU in turn takes the best remaining ready entry
      for (int k = 0; k < NUM_FU; k++) begin
         sel_idx[k] = '0;
`ifdef MULT_RS_AGE_SELECT_EN
         best_age = '0;
`endif
         for (int e = 0; e < RS_SIZE; e++) begin
            if (fu_avail[k] && ent_q[e].valid && ent_q[e].r1 && ent_q[e].r2 && !taken[e]
`ifdef MULT_RS_AGE_SELECT_EN
                && (!sel_ok[k] || age_q[e] > best_age)) begin
               best_age = age_q[e];
`else
                && !sel_ok[k]) begin
`endif
               sel_ok[k]  = 1'b1;
               sel_idx[k] = IDX_W'(e);
            end
         end
         if (sel_ok[k]) taken[sel_idx[k]] = 1'b1;
      end
      for (int e = 0; e < RS_SIZE; e++) begin
         for (int j = N-1; j >= 0; j--) begin
            if (cdb_valid[j] && !ent_q[e].r1 && ent_q[e].t1 == cdb_tag[j*TAG_W +: TAG_W]) begin
               ent_d[e].r1 = 1'b1;
               ent_d[e].v1 = cdb_value[j*DATA_W +: DATA_W];
            end
            if (cdb_valid[j] && !ent_q[e].r2 && ent_q[e].t2 == cdb_tag[j*TAG_W +: TAG_W]) begin
               ent_d[e].r2 = 1'b1;
               ent_d[e].v2 = cdb_value[j*DATA_W +: DATA_W];
            end
         end
         if (taken[e]) ent_d[e].valid = 1'b0;
`ifdef MULT_RS_AGE_SELECT_EN
         age_d[e] = (ent_q[e].valid && |dispatch_valid && age_q[e] != IDX_W'(RS_SIZE-1)) ?
                    age_q[e] + 1'b1 : age_q[e];
`endif
      end
      // dispatch only into entries already free in the registered state
      for (int i = 0; i < N; i++) begin
         found = 1'b0;
         for (int e = 0; e < RS_SIZE; e++) begin
            if (dispatch_valid[i] && !found && !ent_q[e].valid && !alloc[e]) begin
               found          = 1'b1;
               alloc[e]       = 1'b1;
               ent_d[e].valid = 1'b1;
               ent_d[e].op    = dispatch_op[i*OP_W +: OP_W];
               ent_d[e].r1    = dispatch_src1_ready[i];
               ent_d[e].t1    = dispatch_src1_tag[i*TAG_W +: TAG_W];
               ent_d[e].v1    = dispatch_src1_value[i*DATA_W +: DATA_W];
               ent_d[e].r2    = dispatch_src2_ready[i];
               ent_d[e].t2    = dispatch_src2_tag[i*TAG_W +: TAG_W];
               ent_d[e].v2    = dispatch_src2_value[i*DATA_W +: DATA_W];
               ent_d[e].dest  = dispatch_dest_tag[i*TAG_W +: TAG_W];
               ent_d[e].rob   = dispatch_rob_idx[i*ROB_W +: ROB_W];
`ifdef MULT_RS_AGE_SELECT_EN
               age_d[e]       = '0;
`endif
               for (int j = N-1; j >= 0; j--) begin
                  if (cdb_valid[j] && !dispatch_src1_ready[i] &&
                      dispatch_src1_tag[i*TAG_W +: TAG_W] == cdb_tag[j*TAG_W +: TAG_W]) begin
                     ent_d[e].r1 = 1'b1;
                     ent_d[e].v1 = cdb_value[j*DATA_W +: DATA_W];
                  end
                  if (cdb_valid[j] && !dispatch_src2_ready[i] &&
                      dispatch_src2_tag[i*TAG_W +: TAG_W] == cdb_tag[j*TAG_W +: TAG_W]) begin
                     ent_d[e].r2 = 1'b1;
                     ent_d[e].v2 = cdb_value[j*DATA_W +: DATA_W];
                  end
               end
            end
         end
      end
      for (int k = 0; k < NUM_FU; k++) begin
         iv_d[k]                     = sel_ok[k] && !squash;
         iop_d[k*OP_W +: OP_W]       = iv_d[k] ? ent_q[sel_idx[k]].op : '0;
         is1_d[k*DATA_W +: DATA_W]   = iv_d[k] ? ent_q[sel_idx[k]].v1 : '0;
         is2_d[k*DATA_W +: DATA_W]   = iv_d[k] ? ent_q[sel_idx[k]].v2 : '0;
         idest_d[k*TAG_W +: TAG_W]   = iv_d[k] ? ent_q[sel_idx[k]].dest : '0;
         irob_d[k*ROB_W +: ROB_W]    = iv_d[k] ? ent_q[sel_idx[k]].rob : '0;
      end
      if (squash) for (int e = 0; e < RS_SIZE; e++) ent_d[e].valid = 1'b0;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int e = 0; e < RS_SIZE; e++) ent_q[e] <= '0;
`ifdef MULT_RS_AGE_SELECT_EN
         for (int e = 0; e < RS_SIZE; e++) age_q[e] <= '0;
`endif
         iv_q    <= '0;
         iop_q   <= '0;
         is1_q   <= '0;
         is2_q   <= '0;
         idest_q <= '0;
         irob_q  <= '0;
      end else begin
         ent_q   <= ent_d;
`ifdef MULT_RS_AGE_SELECT_EN
         age_q   <= age_d;
`endif
         iv_q    <= iv_d;
         iop_q   <= iop_d;
         is1_q   <= is1_d;
         is2_q   <= is2_d;
         idest_q <= idest_d;
         irob_q  <= irob_d;
      end
   end
   assign issue_valid    = iv_q;
   assign issue_op       = iop_q;
   assign issue_src1     = is1_q;
   assign issue_src2     = is2_q;
   assign issue_dest_tag = idest_q;
   assign issue_rob_idx  = irob_q;
   assign free_count     = free_cnt;
   a_dispatch_fits: assert property (@(posedge clock) disable iff (reset || squash) disp_cnt <= free_cnt);
endmodule

// File: tb/tb_mult_issue_rs.sv
// tb_mult_issue_rs: directed plus randomized scoreboard bench for mult_issue_rs.
module tb_mult_issue_rs;
   localparam int RS = 8, N = 2, NF = 2, TW = 6, DW = 32, RW = 5, OW = 4, CW = 4;
   logic              clock = 1'b0, reset = 1'b1, squash = 1'b0;
   logic [N-1:0]      dispatch_valid = '0, dispatch_src1_ready = '0, dispatch_src2_ready = '0;
   logic [N*OW-1:0]   dispatch_op = '0;
   logic [N*TW-1:0]   dispatch_src1_tag = '0, dispatch_src2_tag = '0, dispatch_dest_tag = '0;
   logic [N*DW-1:0]   dispatch_src1_value = '0, dispatch_src2_value = '0;
   logic [N*RW-1:0]   dispatch_rob_idx = '0;
   logic [N-1:0]      cdb_valid = '0;
   logic [N*TW-1:0]   cdb_tag = '0;
   logic [N*DW-1:0]   cdb_value = '0;
   logic [NF-1:0]     fu_avail = '0;
   logic [NF-1:0]     issue_valid;
   logic [NF*OW-1:0]  issue_op;
   logic [NF*DW-1:0]  issue_src1, issue_src2;
   logic [NF*TW-1:0]  issue_dest_tag;
   logic [NF*RW-1:0]  issue_rob_idx;
   logic [CW-1:0]     free_count;
   always #5 clock = ~clock;
   mult_issue_rs dut (
      .clock(clock), .reset(reset), .squash(squash),
      .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
      .dispatch_src1_ready(dispatch_src1_ready), .dispatch_src1_tag(dispatch_src1_tag),
      .dispatch_src1_value(dispatch_src1_value), .dispatch_src2_ready(dispatch_src2_ready),
      .dispatch_src2_tag(dispatch_src2_tag), .dispatch_src2_value(dispatch_src2_value),
      .dispatch_dest_tag(dispatch_dest_tag), .dispatch_rob_idx(dispatch_rob_idx),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .fu_avail(fu_avail),
      .issue_valid(issue_valid), .issue_op(issue_op), .issue_src1(issue_src1),
      .issue_src2(issue_src2), .issue_dest_tag(issue_dest_tag), .issue_rob_idx(issue_rob_idx),
      .free_count(free_count)
   );
   typedef struct {
      bit          v;
      bit [OW-1:0] op;
      bit          r1;
      bit [TW-1:0] t1;
      bit [DW-1:0] v1;
      bit          r2;
      bit [TW-1:0] t2;
      bit [DW-1:0] v2;
      bit [TW-1:0] dest;
      bit [RW-1:0] rob;
      int          stamp;
   } ment_t;
   typedef struct {
      int          cyc;
      bit [OW-1:0] op;
      bit [DW-1:0] s1;
      bit [DW-1:0] s2;
      bit [TW-1:0] dest;
      bit [RW-1:0] rob;
   } pkt_t;
   ment_t m [RS];
   pkt_t  exp_q [NF][$];
   int    compared = 0, mismatched = 0, cyc = 0, ev = 0;
   always @(posedge clock) cyc <= cyc + 1;
   function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, req);
      end
   endfunction
   function automatic int model_free();
      int f = 0;
      for (int x = 0; x < RS; x++) if (!m[x].v) f++;
      return f;
   endfunction
   // lower value = higher select priority
   function automatic int prio(int x);
`ifdef MULT_RS_AGE_SELECT_EN
      int a = ev - m[x].stamp;
      if (a > RS - 1) a = RS - 1;
      return (RS - 1 - a) * RS + x;
`else
      return x;
`endif
   endfunction
   function automatic bit cdb_hit(bit [TW-1:0] t, output bit [DW-1:0] val);
      val = '0;
      for (int j = 0; j < N; j++)
         if (cdb_valid[j] && cdb_tag[j*TW +: TW] == t) begin
            val = cdb_value[j*DW +: DW];
            return 1'b1;
         end
      return 1'b0;
   endfunction
   task automatic model_step();
      int fr[$];
      bit gone [RS];
      int pick, d;
      bit [DW-1:0] val;
      pkt_t p;
      if (reset || squash) begin
         for (int x = 0; x < RS; x++) m[x].v = 1'b0;
         return;
      end
      for (int x = 0; x < RS; x++) if (!m[x].v) fr.push_back(x);
      for (int k = 0; k < NF; k++) begin
         pick = -1;
         if (fu_avail[k])
            for (int x = 0; x < RS; x++)
               if (m[x].v && m[x].r1 && m[x].r2 && !gone[x] && (pick < 0 || prio(x) < prio(pick))) pick = x;
         if (pick >= 0) begin
            gone[pick] = 1'b1;
            p.cyc = cyc + 1; p.op = m[pick].op; p.s1 = m[pick].v1; p.s2 = m[pick].v2;
            p.dest = m[pick].dest; p.rob = m[pick].rob;
            exp_q[k].push_back(p);
         end
      end
      for (int x = 0; x < RS; x++) begin
         if (m[x].v && gone[x]) m[x].v = 1'b0;
         else if (m[x].v) begin
            if (!m[x].r1 && cdb_hit(m[x].t1, val)) begin m[x].r1 = 1'b1; m[x].v1 = val; end
            if (!m[x].r2 && cdb_hit(m[x].t2, val)) begin m[x].r2 = 1'b1; m[x].v2 = val; end
         end
      end
      if (|dispatch_valid) ev++;
      d = 0;
      for (int i = 0; i < N; i++) begin
         if (dispatch_valid[i]) begin
            pick = fr[d];
            d++;
            m[pick].v = 1'b1; m[pick].op = dispatch_op[i*OW +: OW];
            m[pick].r1 = dispatch_src1_ready[i]; m[pick].t1 = dispatch_src1_tag[i*TW +: TW];
            m[pick].v1 = dispatch_src1_value[i*DW +: DW];
            m[pick].r2 = dispatch_src2_ready[i]; m[pick].t2 = dispatch_src2_tag[i*TW +: TW];
            m[pick].v2 = dispatch_src2_value[i*DW +: DW];
            m[pick].dest = dispatch_dest_tag[i*TW +: TW]; m[pick].rob = dispatch_rob_idx[i*RW +: RW];
            m[pick].stamp = ev;
            if (!m[pick].r1 && cdb_hit(m[pick].t1, val)) begin m[pick].r1 = 1'b1; m[pick].v1 = val; end
            if (!m[pick].r2 && cdb_hit(m[pick].t2, val)) begin m[pick].r2 = 1'b1; m[pick].v2 = val; end
         end
      end
   endtask
   task automatic disp(int i, bit [OW-1:0] op, bit r1, bit [TW-1:0] t1, bit [DW-1:0] v1,
                       bit r2, bit [TW-1:0] t2, bit [DW-1:0] v2, bit [TW-1:0] dest, bit [RW-1:0] rob);
      dispatch_valid[i] = 1'b1;
      dispatch_op[i*OW +: OW] = op;
      dispatch_src1_ready[i] = r1; dispatch_src1_tag[i*TW +: TW] = t1; dispatch_src1_value[i*DW +: DW] = v1;
      dispatch_src2_ready[i] = r2; dispatch_src2_tag[i*TW +: TW] = t2; dispatch_src2_value[i*DW +: DW] = v2;
      dispatch_dest_tag[i*TW +: TW] = dest; dispatch_rob_idx[i*RW +: RW] = rob;
   endtask
   task automatic cdb(int j, bit [TW-1:0] t, bit [DW-1:0] v);
      cdb_valid[j] = 1'b1;
      cdb_tag[j*TW +: TW] = t;
      cdb_value[j*DW +: DW] = v;
   endtask
   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
      dispatch_valid = '0;
      cdb_valid = '0;
      squash = 1'b0;
      chk("free_count", free_count, model_free());
   endtask
   always @(negedge clock) begin : mon
      pkt_t p;
      if (cyc > 0) begin
         for (int k = 0; k < NF; k++) begin
            if (issue_valid[k]) begin
               if (exp_q[k].size() == 0) chk($sformatf("fu%0d_unexpected_issue", k), 1, 0);
               else begin
                  p = exp_q[k].pop_front();
                  chk($sformatf("fu%0d_issue_cycle", k), cyc, p.cyc);
                  chk($sformatf("fu%0d_op", k), issue_op[k*OW +: OW], p.op);
                  chk($sformatf("fu%0d_src1", k), issue_src1[k*DW +: DW], p.s1);
                  chk($sformatf("fu%0d_src2", k), issue_src2[k*DW +: DW], p.s2);
                  chk($sformatf("fu%0d_dest", k), issue_dest_tag[k*TW +: TW], p.dest);
                  chk($sformatf("fu%0d_rob", k), issue_rob_idx[k*RW +: RW], p.rob);
               end
            end else begin
               chk($sformatf("fu%0d_idle_data", k),
                   {issue_op[k*OW +: OW], issue_dest_tag[k*TW +: TW], issue_rob_idx[k*RW +: RW]}, 0);
               if (exp_q[k].size() != 0 && exp_q[k][0].cyc <= cyc) begin
                  chk($sformatf("fu%0d_missing_issue", k), 0, 1);
                  void'(exp_q[k].pop_front());
               end
            end
         end
      end
   end
   initial begin
      int n, t0;
      fu_avail = 2'b11;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("reset_issue_valid", issue_valid, 0);
      chk("reset_free_count", free_count, 8);
      // single ready dispatch
      disp(0, 4'd1, 1, 0, 3, 1, 0, 5, 12, 4);
      tick();
      chk("tp1_free_after_dispatch", free_count, 7);
      chk("tp1_not_yet", issue_valid, 0);
      tick();
      chk("tp1_issue_valid", issue_valid, 2'b01);
      chk("tp1_src1", issue_src1[DW-1:0], 3);
      chk("tp1_src2", issue_src2[DW-1:0], 5);
      chk("tp1_dest", issue_dest_tag[TW-1:0], 12);
      chk("tp1_rob", issue_rob_idx[RW-1:0], 4);
      chk("tp1_free_after_issue", free_count, 8);
      tick();
      // wakeup via CDB
      disp(0, 4'd2, 0, 9, 0, 1, 0, 6, 13, 5);
      tick();
      tick();
      cdb(0, 9, 32'h10);
      tick();
      chk("tp2_not_yet", issue_valid, 0);
      tick();
      chk("tp2_issue_valid", issue_valid, 2'b01);
      chk("tp2_src1", issue_src1[DW-1:0], 32'h10);
      // same-cycle dispatch bypass
      disp(0, 4'd3, 0, 9, 0, 1, 0, 2, 14, 6);
      cdb(1, 9, 7);
      tick();
      tick();
      chk("tp3_issue_valid", issue_valid, 2'b01);
      chk("tp3_src1", issue_src1[DW-1:0], 7);
      // fill to full, only FU1 available
      fu_avail = 2'b00;
      for (int c = 0; c < 4; c++) begin
         disp(0, 4'(c), 1, 0, 100 + 2*c, 1, 0, 2*c, 6'(2*c), 5'(2*c));
         disp(1, 4'(c), 1, 0, 101 + 2*c, 1, 0, 2*c + 1, 6'(2*c + 1), 5'(2*c + 1));
         tick();
      end
      chk("tp4_full", free_count, 0);
      fu_avail = 2'b10;
      for (int c = 0; c < 8; c++) begin
         tick();
         chk("tp4_fu1_only", issue_valid, 2'b10);
      end
      tick();
      chk("tp4_drained", issue_valid, 0);
      // squash with an issue in flight
      fu_avail = 2'b00;
      disp(0, 4'd5, 1, 0, 1, 1, 0, 1, 1, 1); disp(1, 4'd5, 1, 0, 2, 1, 0, 2, 2, 2); tick();
      disp(0, 4'd5, 1, 0, 3, 1, 0, 3, 3, 3); disp(1, 4'd5, 1, 0, 4, 1, 0, 4, 4, 4); tick();
      disp(0, 4'd5, 0, 9, 0, 1, 0, 5, 5, 5); tick();
      fu_avail = 2'b11;
      tick();
      chk("tp5_in_flight", issue_valid, 2'b11);
      squash = 1'b1;
      cdb(0, 9, 32'h55);
      tick();
      chk("tp5_squash_issue_valid", issue_valid, 0);
      chk("tp5_squash_free", free_count, 8);
      tick();
      chk("tp5_no_late_issue", issue_valid, 0);
      // two waiters on one tag
      disp(0, 4'd7, 0, 20, 0, 1, 0, 11, 21, 7);
      disp(1, 4'd8, 0, 20, 0, 1, 0, 12, 22, 8);
      tick();
      tick();
      cdb(1, 20, 32'hABC);
      tick();
      tick();
      chk("tp6_both_issue", issue_valid, 2'b11);
      // randomized traffic
      repeat (600) begin
         fu_avail = NF'($urandom);
         n = $urandom_range(0, N);
         if (n > model_free()) n = model_free();
         for (int i = 0; i < n; i++)
            disp(i, OW'($urandom), $urandom_range(0, 2) != 0, TW'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 2) != 0, TW'($urandom_range(0, 7)), $urandom,
                 TW'($urandom), RW'($urandom));
         t0 = $urandom_range(0, 7);
         if ($urandom_range(0, 1) == 1) cdb(0, TW'(t0), $urandom);
         if ($urandom_range(0, 1) == 1) cdb(1, TW'((t0 + $urandom_range(1, 7)) % 8), $urandom);
         squash = ($urandom_range(0, 49) == 0);
         tick();
      end
      fu_avail = 2'b11;
      repeat (4) tick();
      for (int k = 0; k < NF; k++) chk($sformatf("fu%0d_queue_drained", k), exp_q[k].size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/mult_issue_rs.md
Name: mult_issue_rs

Overview:
- Reservation station for the multiply functional units. Sits directly upstream of the FU/CDB stage and produces its multiply issue packets.
- Accepts up to N dispatched instructions per cycle and wakes up operands from CDB broadcasts.
- Issues ready instructions to free multiply FUs, gated by the per-FU availability the FU/CDB stage reports.

Parameters:
- RS_SIZE, 8, number of entries.
- N, 2, dispatch width and CDB broadcast width.
- NUM_FU, 2, number of multiply FUs.
- TAG_W, 6, physical register tag width.
- DATA_W, 32, operand width.
- ROB_W, 5, ROB index width.
- OP_W, 4, multiply opcode width.
- CNT_W, $clog2(RS_SIZE+1), width of free_count.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- squash  in  1  flush all entries (branch mispredict).
- dispatch_valid  in  N  per-slot dispatch request.
- dispatch_op  in  N*OP_W  opcode.
- dispatch_src1_ready  in  N  operand 1 value already known.
- dispatch_src1_tag  in  N*TAG_W  operand 1 tag.
- dispatch_src1_value  in  N*DATA_W  operand 1 value; valid if ready.
- dispatch_src2_ready  in  N  operand 2 value already known.
- dispatch_src2_tag  in  N*TAG_W  operand 2 tag.
- dispatch_src2_value  in  N*DATA_W  operand 2 value; valid if ready.
- dispatch_dest_tag  in  N*TAG_W  destination tag.
- dispatch_rob_idx  in  N*ROB_W  ROB index.
- cdb_valid  in  N  broadcast valid.
- cdb_tag  in  N*TAG_W  broadcast tag.
- cdb_value  in  N*DATA_W  broadcast value.
- fu_avail  in  NUM_FU  FU k can accept a packet in the next cycle.
- issue_valid  out  NUM_FU  registered issue packet valid, one per FU.
- issue_op  out  NUM_FU*OP_W  opcode.
- issue_src1  out  NUM_FU*DATA_W  operand 1.
- issue_src2  out  NUM_FU*DATA_W  operand 2.
- issue_dest_tag  out  NUM_FU*TAG_W  destination tag.
- issue_rob_idx  out  NUM_FU*ROB_W  ROB index.
- free_count  out  CNT_W  number of invalid entries in current registered state.

Behaviour:
- Entry state: valid, op, src1/src2 ready/tag/value, dest_tag, rob_idx.
- Reset or squash (sampled at an edge):
  - All entries invalid.
  - All issue_* outputs zero.
  - free_count = RS_SIZE on the following cycle.
  - Dispatch and select in that same cycle are discarded.
  - Squash takes precedence over everything else.
- Dispatch:
  - Upstream guarantees popcount(dispatch_valid) <= free_count. Behaviour when violated is undefined; a debug assertion flags it.
  - Slot i is written to the i-th lowest-index invalid entry at the edge.
  - Dispatch is not allowed to use entries freed by issue in the same cycle.
- Dispatch bypass: if a dispatched operand is not ready and its tag matches any valid CDB tag in the same cycle, the entry is written ready with that CDB value.
- Wakeup:
  - Every valid, not-ready operand whose tag equals cdb_tag[j] with cdb_valid[j] becomes ready with cdb_value[j] at the edge.
  - If several CDB slots match, the lowest j wins; the codebase guarantees tags are unique.
- Select (combinational on registered entries):
  - An entry is ready when both operands are ready.
  - Ready entries are assigned to FUs with fu_avail=1 in ascending FU index, taking entries in priority order (see Optional Feature).
  - At most NUM_FU entries are selected per cycle.
  - An entry woken at edge t is selectable in cycle t and can issue at edge t+1. There is no same-cycle CDB-to-issue forwarding.
- Issue timing:
  - Selected entries are invalidated at the edge.
  - Their packets appear on issue_* of the corresponding FU for exactly one cycle after that edge.
  - issue_valid[k]=0 when nothing is selected for FU k; issue data is then don't-care and driven zero.
  - Latency: dispatch with both operands ready at edge t gives the earliest issue_valid after edge t+1.
- free_count: counts invalid entries of the registered state. Entries freed at edge t are counted from t+1.
- Full: free_count=0 means dispatch must not be requested. Select and issue continue normally.

Optional Feature:
- Macro: MULT_RS_AGE_SELECT_EN.
- Defined:
  - Each entry holds an age counter of width $clog2(RS_SIZE).
  - On dispatch the age is set to 0. All other valid entries increment, saturating at RS_SIZE-1.
  - Select takes the oldest ready entries first; ties go to lower index.
- Undefined: select priority is strictly lowest entry index. No age storage.

Test Plan:
- Reset, then one dispatch with both operands ready (op=MUL, src1=3, src2=5, dest=12, rob=4), fu_avail=2'b11 -> issue_valid=2'b01 one cycle after the dispatch edge, src1=3, src2=5, dest=12, rob=4; free_count 8->7->8.
- Dispatch src1 not ready with tag 9; CDB broadcasts tag 9, value 0x10 two cycles later -> issue_valid rises the cycle after the wakeup edge with src1=0x10.
- Same-cycle dispatch and CDB on tag 9 (value 7) -> entry captured ready with 7; issues next cycle.
- Fill all 8 entries with ready ops, fu_avail=2'b10 -> only FU1 issues, one per cycle. With age enabled, issue order equals dispatch order; without it, order is by entry index.
- Squash with 5 valid entries and an issue in flight -> next cycle issue_valid=0, free_count=8; a CDB match in the squash cycle has no effect.
- Two entries waiting on tag 20, CDB tag 20 -> both issue in the same cycle on FU0 and FU1 when fu_avail=2'b11.
